// File: rtl/d_flip_flop.sv
// d_flip_flop: WIDTH-bit D-type register with a synchronous active-low reset
// and a complemented output.
//
// Each bit is an independent flip-flop. All bits share clk and rst_n.
// Q_hat is the bitwise complement of the stored value, so it can never
// disagree with Q.
module d_flip_flop #(
   parameter int unsigned            WIDTH       = 1,
   parameter logic [WIDTH-1:0]       RESET_VALUE = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] data_input,
   output logic [WIDTH-1:0] Q,
   output logic [WIDTH-1:0] Q_hat
);

   // Catch out-of-range widths when the design is elaborated.
   if (WIDTH < 1 || WIDTH > 64) begin : g_width_check
      $error("d_flip_flop: WIDTH must be in 1..64");
   end

   logic [WIDTH-1:0] q_d;
   logic [WIDTH-1:0] q_q;

   // Next state is always the D input. Reset is applied in the register below.
   always_comb begin
      q_d = data_input;
   end

   // Capture D on every rising edge. Reset wins on the same edge.
   // NOTE: the reset is synchronous. A low rst_n between edges does nothing
   // until the next rising edge, and the reset term is only evaluated inside
   // the clocked block. Non-blocking assignment keeps every bit's update
   // ordered consistently with the clock edge.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         q_q <= RESET_VALUE;
      end else begin
         q_q <= q_d;
      end
   end

   // Drive both outputs from the register. Q_hat is a pure inversion of the
   // register, not of data_input, so it has no skew relative to Q.
   assign Q     = q_q;
   assign Q_hat = ~q_q;

endmodule

// File: tb/tb_d_flip_flop.sv
// Self-checking bench for d_flip_flop.
//
// Two instances run side by side. One uses the defaults (WIDTH=1, reset 0).
// The other uses WIDTH=8 with RESET_VALUE=8'hA5. Each stimulus step pushes
// the expected register contents for the coming edge onto a scoreboard
// queue. After that edge the entry is popped and compared with Q and Q_hat.
module tb_d_flip_flop;

   localparam logic [7:0] RV8 = 8'hA5;

   typedef struct {
      string      tag;
      logic       exp1;
      logic [7:0] exp8;
   } sb_entry_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       d1;
   logic [7:0] d8;
   logic       q1, qh1;
   logic [7:0] q8, qh8;

   sb_entry_t  sb[$];
   int         errors = 0;
   int         checks = 0;

   // Values the register is expected to hold right now. They are used for
   // the mid-cycle hold checks.
   logic       cur1;
   logic [7:0] cur8;

   d_flip_flop u_dut1 (
      .clk        (clk),
      .rst_n      (rst_n),
      .data_input (d1),
      .Q          (q1),
      .Q_hat      (qh1)
   );

   d_flip_flop #(.WIDTH(8), .RESET_VALUE(RV8)) u_dut8 (
      .clk        (clk),
      .rst_n      (rst_n),
      .data_input (d8),
      .Q          (q8),
      .Q_hat      (qh8)
   );

   always #5 clk = ~clk;

   // Watchdog so the run always ends.
   initial begin
      #100000;
      $display("FAIL watchdog: run exceeded time limit");
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   // Pop one scoreboard entry and compare it with both instances.
   task automatic compare_out();
      sb_entry_t e;
      if (sb.size() == 0) begin
         check("scoreboard_empty", 64'd1, 64'd0);
         return;
      end
      e = sb.pop_front();
      check({e.tag, ".q1"},  {63'd0, q1},  {63'd0, e.exp1});
      check({e.tag, ".qh1"}, {63'd0, qh1}, {63'd0, ~e.exp1});
      check({e.tag, ".q8"},  {56'd0, q8},  {56'd0, e.exp8});
      check({e.tag, ".qh8"}, {56'd0, qh8}, {56'd0, ~e.exp8});
      cur1 = e.exp1;
      cur8 = e.exp8;
   endtask

   // Drive inputs just after an edge and predict what the next edge
   // captures. Then wait for that edge and check 1 time unit after it.
   task automatic step(input string tag, input logic r, input logic v1, input logic [7:0] v8);
      sb_entry_t e;
      rst_n = r;
      d1    = v1;
      d8    = v8;
      e.tag  = tag;
      e.exp1 = r ? v1 : 1'b0;
      e.exp8 = r ? v8 : RV8;
      sb.push_back(e);
      @(posedge clk);
      #1;
      compare_out();
   endtask

   // Confirm the outputs still hold the last captured value between edges.
   task automatic check_hold(input string tag);
      check({tag, ".q1"}, {63'd0, q1}, {63'd0, cur1});
      check({tag, ".q8"}, {56'd0, q8}, {56'd0, cur8});
   endtask

   initial begin
      rst_n = 1'b0;
      d1    = 1'b1;
      d8    = 8'hFF;

      // Reset for one edge. data_input is ignored on that edge.
      step("reset", 1'b0, 1'b1, 8'hFF);

      // Capture starts on the first edge after reset, with no dead cycle.
      step("seq0", 1'b1, 1'b0, 8'h3C);
      step("seq1", 1'b1, 1'b1, 8'h00);
      step("seq2", 1'b1, 1'b1, 8'hFF);
      step("seq3", 1'b1, 1'b0, 8'h81);
      step("seq4", 1'b1, 1'b1, 8'h5A);

      // Toggle data_input several times inside one low phase.
      step("pre_glitch", 1'b1, 1'b0, 8'h00);
      @(negedge clk);
      d1 = 1'b1; d8 = 8'hF0;
      #1 d1 = 1'b0; d8 = 8'h0F;
      #1 d1 = 1'b1; d8 = 8'h96;
      #1 check_hold("glitch_hold");
      step("glitch_cap", 1'b1, 1'b1, 8'h96);

      // Reset wins over data on the same edge, then recovers at once.
      step("q_one", 1'b1, 1'b1, 8'h11);
      step("rst_wins", 1'b0, 1'b1, 8'h22);
      step("rst_recover", 1'b1, 1'b1, 8'h33);

      // A reset pulse entirely between two edges has no effect.
      d1 = 1'b0; d8 = 8'h44;
      #1 rst_n = 1'b0;
      #2 check_hold("rst_pulse_hold");
      rst_n = 1'b1;
      step("rst_pulse_cap", 1'b1, 1'b0, 8'h44);

      // Reset asserted mid-operation overrides pending data.
      step("mid_data", 1'b1, 1'b1, 8'hC3);
      step("mid_rst", 1'b0, 1'b1, 8'h7E);

      // Directed check: reset, then 8'h3C.
      step("w8_reset", 1'b0, 1'b0, 8'h00);
      step("w8_3c", 1'b1, 1'b1, 8'h3C);

      // Random traffic with occasional resets.
      for (int i = 0; i < 24; i++) begin
         step($sformatf("rand%0d", i), ($urandom_range(0, 7) != 0),
              1'($urandom), 8'($urandom));
      end

      if (sb.size() != 0) check("scoreboard_leftover", 64'(sb.size()), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
